// File: rtl/i2c_slave_regfile.sv
// I2C target with 7-bit addressing, a pointer byte with auto-increment and no clock
// stretching, fronting a byte register file that core logic can also read and write.
module i2c_slave_regfile #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         NUM_REGS   = 16,
    parameter int         FILTER_LEN = 4,
    localparam int        AW         = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    output logic          scl_o,
    output logic          scl_t,
    input  logic          sda_i,
    output logic          sda_o,
    output logic          sda_t,
    input  logic [AW-1:0] host_addr,
    input  logic          host_wr_en,
    input  logic [7:0]    host_wr_data,
    output logic [7:0]    host_rd_data,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    localparam int             FCW     = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FCW-1:0] FLT_MAX = FCW'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_WDATA,
        ST_WACK,
        ST_RDATA,
        ST_RACK,
        ST_IGNORE
    } state_t;

    state_t         state;
    logic [3:0]     bit_cnt;
    logic [7:0]     shift;
    logic [7:0]     tx_byte;
    logic           rw;
    logic [AW-1:0]  ptr;
    logic [7:0]     regs [NUM_REGS];

    // Index 0 is SCL, index 1 is SDA.
    logic [1:0]     raw;
    logic [1:0]     filt;
    logic [1:0]     filt_q;
    logic [FCW-1:0] flt_cnt [2];

    logic scl_f, sda_f, scl_q, sda_q;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic addr_match, i2c_commit;
    logic [7:0] rx_byte;

    assign raw = {sda_i, scl_i};

    // NOTE: every clocked block uses non-blocking assignments, so each block sees
    // the pre-edge value of every register no matter how blocks are ordered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt   <= 2'b11;
            filt_q <= 2'b11;
            for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
        end else begin
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FLT_MAX) begin
                    filt[i]    <= raw[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + FCW'(1);
                end
            end
        end
    end

    assign scl_f = filt[0];
    assign sda_f = filt[1];
    assign scl_q = filt_q[0];
    assign sda_q = filt_q[1];

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

    assign rx_byte    = {shift[6:0], sda_f};
    assign addr_match = (shift[7:1] == DEV_ADDR) && (shift[7:1] != 7'd0);
    assign i2c_commit = (state == ST_WDATA) && scl_rise && (bit_cnt == 4'd7);

    // NOTE: the register file is reset because its cleared contents are visible to
    // both bus and host after reset; that keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
            host_rd_data <= 8'h00;
        end else begin
            host_rd_data <= regs[host_addr];
            if (host_wr_en && !(i2c_commit && (host_addr == ptr)))
                regs[host_addr] <= host_wr_data;
            if (i2c_commit)
                regs[ptr] <= rx_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            tx_byte   <= '0;
            rw        <= 1'b0;
            ptr       <= '0;
            sda_t     <= 1'b1;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (stop_det) begin
                state   <= ST_IDLE;
                sda_t   <= 1'b1;
                busy    <= 1'b0;
                bit_cnt <= '0;
            end else if (start_det) begin
                state   <= ST_ADDR;
                sda_t   <= 1'b1;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (addr_match) begin
                                sda_t <= 1'b0;
                                busy  <= 1'b1;
                                rw    <= shift[0];
                                state <= ST_ADDR_ACK;
                            end else begin
                                busy  <= 1'b0;
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                tx_byte <= regs[ptr];
                                sda_t   <= regs[ptr][7];
                                state   <= ST_RDATA;
                            end else begin
                                sda_t <= 1'b1;
                                state <= ST_PTR;
                            end
                        end
                    end
                    ST_PTR, ST_WDATA: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (state == ST_PTR) begin
                                    ptr <= rx_byte[AW-1:0];
                                end else begin
                                    wr_strobe <= 1'b1;
                                    wr_addr   <= ptr;
                                    wr_data   <= rx_byte;
                                    ptr       <= ptr + AW'(1);
                                end
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            sda_t   <= 1'b0;
                            state   <= ST_WACK;
                        end
                    end
                    ST_WACK: begin
                        if (scl_fall) begin
                            sda_t <= 1'b1;
                            state <= ST_WDATA;
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) ptr <= ptr + AW'(1);
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= '0;
                                sda_t   <= 1'b1;
                                state   <= ST_RACK;
                            end else if (bit_cnt != 4'd0) begin
                                sda_t   <= tx_byte[6];
                                tx_byte <= {tx_byte[6:0], 1'b1};
                            end
                        end
                    end
                    ST_RACK: begin
                        // SDA high on the ACK clock is a NACK: the initiator is done reading.
                        if (scl_rise && sda_f) begin
                            busy  <= 1'b0;
                            state <= ST_IGNORE;
                        end else if (scl_fall) begin
                            tx_byte <= regs[ptr];
                            sda_t   <= regs[ptr][7];
                            bit_cnt <= '0;
                            state   <= ST_RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_o = sda_t;
    assign scl_o = 1'b1;
    assign scl_t = 1'b1;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench: a behavioural I2C initiator plus a register/pointer reference
// model, driven by directed cases and randomized transactions.
module tb_i2c_slave_regfile;

    localparam int         NUM_REGS = 16;
    localparam int         AW       = 4;
    localparam int         Q        = 8;
    localparam logic [6:0] DEV      = 7'h50;

    logic          clk = 1'b0;
    logic          rst;
    logic          scl_m, sda_m;
    logic          scl_o, scl_t, sda_o, sda_t;
    logic [AW-1:0] host_addr;
    logic          host_wr_en;
    logic [7:0]    host_wr_data, host_rd_data;
    logic          wr_strobe;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;

    wire scl_bus = scl_m & (scl_t | scl_o);
    wire sda_bus = sda_m & (sda_t | sda_o);

    i2c_slave_regfile #(.DEV_ADDR(DEV), .NUM_REGS(NUM_REGS), .FILTER_LEN(4)) dut (
        .clk(clk), .rst(rst),
        .scl_i(scl_bus), .scl_o(scl_o), .scl_t(scl_t),
        .sda_i(sda_bus), .sda_o(sda_o), .sda_t(sda_t),
        .host_addr(host_addr), .host_wr_en(host_wr_en),
        .host_wr_data(host_wr_data), .host_rd_data(host_rd_data),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  m_regs [NUM_REGS];
    int          m_ptr;
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    logic [7:0]  tx_q  [$];

    always @(negedge clk) begin
        if (wr_strobe) got_q.push_back({8'(wr_addr), wr_data});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_commit(input logic [7:0] b);
        m_regs[m_ptr] = b;
        exp_q.push_back({8'(m_ptr), b});
        m_ptr = (m_ptr + 1) % NUM_REGS;
    endtask

    // mode 0: plain bit; 1: host write to the commit address on the commit cycle;
    // 2: 2-cycle inverted SDA glitch while SCL high; 3: host write to another address on the commit cycle.
    task automatic bit_cycle(input logic b, input int mode, input logic [7:0] hdata, output logic smp);
        sda_m = b;
        wait_clk(Q);
        scl_m = 1'b1;
        if (mode == 1 || mode == 3) begin
            wait_clk(4);
            host_addr    = (mode == 1) ? AW'(m_ptr) : AW'((m_ptr + 1) % NUM_REGS);
            host_wr_data = hdata;
            host_wr_en   = 1'b1;
            if (mode == 3) m_regs[(m_ptr + 1) % NUM_REGS] = hdata;
            wait_clk(1);
            host_wr_en = 1'b0;
            check("commit_strobe_timing", wr_strobe, 1'b1);
            wait_clk(Q - 5);
        end else if (mode == 2) begin
            wait_clk(3);
            sda_m = ~b;
            wait_clk(2);
            sda_m = b;
            wait_clk(Q - 5);
        end else begin
            wait_clk(Q);
        end
        smp = sda_bus;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hbit, input int mode,
                             input logic [7:0] hdata, output logic ack);
        logic smp;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], (i == hbit) ? mode : 0, hdata, smp);
        bit_cycle(1'b1, 0, 8'h00, ack);
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] b);
        logic smp;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, 0, 8'h00, smp);
            b[i] = smp;
        end
        bit_cycle(master_ack ? 1'b0 : 1'b1, 0, 8'h00, smp);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic check_strobes();
        check("strobe_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check("strobe_addr_data", got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic host_write(input int a, input logic [7:0] d);
        host_addr    = AW'(a);
        host_wr_data = d;
        host_wr_en   = 1'b1;
        wait_clk(1);
        host_wr_en   = 1'b0;
        m_regs[a]    = d;
    endtask

    task automatic check_regs();
        for (int i = 0; i < NUM_REGS; i++) begin
            host_addr = AW'(i);
            wait_clk(1);
            check($sformatf("reg[%0d]", i), host_rd_data, m_regs[i]);
        end
    endtask

    // First byte in tx_q is the pointer; the rest are data bytes.
    task automatic do_write(input logic [6:0] a, input bit with_stop);
        logic ack;
        i2c_start();
        send_byte({a, 1'b0}, -1, 0, 8'h00, ack);
        check("addr_ack", ack, (a == DEV) ? 1'b0 : 1'b1);
        if (a == DEV) begin
            check("busy_addressed", busy, 1'b1);
            foreach (tx_q[i]) begin
                send_byte(tx_q[i], -1, 0, 8'h00, ack);
                check("data_ack", ack, 1'b0);
                if (i == 0) m_ptr = int'(tx_q[0]) % NUM_REGS;
                else        model_commit(tx_q[i]);
            end
        end else begin
            check("busy_not_addressed", busy, 1'b0);
        end
        if (with_stop) begin
            i2c_stop();
            check("busy_after_stop", busy, 1'b0);
        end
        check_strobes();
    endtask

    task automatic do_read(input int n);
        logic       ack;
        logic [7:0] b;
        i2c_start();
        send_byte({DEV, 1'b1}, -1, 0, 8'h00, ack);
        check("read_addr_ack", ack, 1'b0);
        for (int i = 0; i < n; i++) begin
            recv_byte(i < n - 1, b);
            check("read_data", b, m_regs[m_ptr]);
            m_ptr = (m_ptr + 1) % NUM_REGS;
        end
        check("sda_released_after_nack", sda_t, 1'b1);
        i2c_stop();
        check("busy_after_read", busy, 1'b0);
    endtask

    initial begin
        logic       ack, smp;
        int         guard, op;
        logic [6:0] a;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        host_addr = '0; host_wr_en = 1'b0; host_wr_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);

        check("reset_sda_t", sda_t, 1'b1);
        check("reset_sda_o", sda_o, 1'b1);
        check("reset_scl_o_t", {scl_o, scl_t}, 2'b11);
        check("reset_strobe", {wr_strobe, 4'(wr_addr), wr_data}, 13'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_host_rd", host_rd_data, 8'h00);

        // Pointer 3, two data bytes.
        tx_q = '{8'h03, 8'hA5, 8'h5A};
        do_write(DEV, 1'b1);
        check_regs();

        // Pointer write, repeated START, read with ACK then NACK.
        tx_q = '{8'h03};
        do_write(DEV, 1'b0);
        do_read(2);

        // Wrong address: no ACK, no commit.
        tx_q = '{8'h00, 8'hEE};
        do_write(7'h51, 1'b1);
        check_regs();

        // Pointer wrap at the top of the file.
        tx_q = '{8'h0F, 8'h11, 8'h22};
        do_write(DEV, 1'b1);
        check_regs();

        // STOP mid data byte: no commit, no pointer movement.
        i2c_start();
        send_byte({DEV, 1'b0}, -1, 0, 8'h00, ack);
        send_byte(8'h07, -1, 0, 8'h00, ack);
        m_ptr = 7;
        for (int i = 0; i < 5; i++) bit_cycle(1'b1, 0, 8'h00, smp);
        i2c_stop();
        check("partial_sda_t", sda_t, 1'b1);
        check("partial_busy", busy, 1'b0);
        check_strobes();
        do_read(1);

        // SDA glitches while SCL high are filtered out.
        i2c_start();
        send_byte({DEV, 1'b0}, -1, 0, 8'h00, ack);
        send_byte(8'h09, -1, 0, 8'h00, ack);
        m_ptr = 9;
        send_byte(8'h81, 7, 2, 8'h00, ack);
        check("glitch_start_ack", ack, 1'b0);
        model_commit(8'h81);
        send_byte(8'h7E, 7, 2, 8'h00, ack);
        check("glitch_stop_ack", ack, 1'b0);
        model_commit(8'h7E);
        i2c_stop();
        check_strobes();
        check_regs();

        // Host/I2C collisions: same address (I2C wins), different address (both land).
        i2c_start();
        send_byte({DEV, 1'b0}, -1, 0, 8'h00, ack);
        send_byte(8'h04, -1, 0, 8'h00, ack);
        m_ptr = 4;
        send_byte(8'hC3, 0, 1, 8'h77, ack);
        model_commit(8'hC3);
        send_byte(8'h3D, 0, 3, 8'h99, ack);
        model_commit(8'h3D);
        i2c_stop();
        check_strobes();
        check_regs();

        // Randomized traffic.
        for (int it = 0; it < 24; it++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: begin
                    tx_q.delete();
                    tx_q.push_back(8'($urandom));
                    repeat ($urandom_range(0, 3)) tx_q.push_back(8'($urandom));
                    do_write(DEV, 1'b1);
                end
                1: do_read($urandom_range(1, 3));
                2: begin
                    tx_q.delete();
                    tx_q.push_back(8'($urandom));
                    do_write(DEV, 1'b0);
                    do_read($urandom_range(1, 2));
                end
                3: begin
                    host_write($urandom_range(0, NUM_REGS - 1), 8'($urandom));
                    host_write($urandom_range(0, NUM_REGS - 1), 8'($urandom));
                end
                default: begin
                    a = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'($urandom);
                    if (a == DEV) a = 7'h51;
                    tx_q = '{8'h01, 8'hFF};
                    do_write(a, 1'b1);
                end
            endcase
            check_regs();
        end

        // Reset while the target drives a '0' read bit.
        host_write(m_ptr, 8'h3C);
        i2c_start();
        send_byte({DEV, 1'b1}, -1, 0, 8'h00, ack);
        guard = 0;
        while (sda_t !== 1'b0 && guard < 40) begin
            wait_clk(1);
            guard++;
        end
        check("read_bit0_driven", sda_t, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("reset_releases_sda", sda_t, 1'b1);
        wait_clk(2);
        sda_m = 1'b1;
        scl_m = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        got_q.delete();
        exp_q.delete();
        wait_clk(2);
        check("post_reset_busy", busy, 1'b0);
        check_regs();
        host_write(0, 8'h6B);
        do_read(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
